// File: rtl/exe_stage.sv
// Execute stage: Val2 generator, ALU, NZCV status register, branch target adder, EX/MEM register.
// Optional operand forwarding muxes are built when EXE_FORWARDING_EN is defined.
module exe_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        WB_EN_In,
  input  logic        MEM_R_EN_In,
  input  logic        MEM_W_EN_In,
  input  logic [3:0]  EXE_CMD_In,
  input  logic        B_In,
  input  logic        S_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] Val_Rn_In,
  input  logic [31:0] Val_Rm_In,
  input  logic        imm_In,
  input  logic [11:0] Shift_operand_In,
  input  logic [23:0] Signed_imm_24_In,
  input  logic [3:0]  Dest_In,
  input  logic [3:0]  SR_In,
`ifdef EXE_FORWARDING_EN
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] MEM_ALU_Res,
  input  logic [31:0] WB_Value,
`endif
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic [3:0]  SR,
  output logic        WB_EN_Out,
  output logic        MEM_R_EN_Out,
  output logic        MEM_W_EN_Out,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm_Out,
  output logic [3:0]  Dest_Out
);

  typedef enum logic [3:0] {
    OP_MOV = 4'b0001,
    OP_ADD = 4'b0010,
    OP_ADC = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SBC = 4'b0101,
    OP_AND = 4'b0110,
    OP_ORR = 4'b0111,
    OP_EOR = 4'b1000,
    OP_MVN = 4'b1001
  } alu_op_e;

  logic [31:0] op_a, op_rm, val2;
  logic [31:0] imm_rot, rm_shift, res;
  logic [32:0] sum;
  logic        cin, c_new, v_new, flag_upd;
  logic        unused_sr_bits;

  assign cin            = SR_In[1];
  assign unused_sr_bits = ^{SR_In[3:2], SR_In[0]};

`ifdef EXE_FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   op_a = MEM_ALU_Res;
      2'b10:   op_a = WB_Value;
      default: op_a = Val_Rn_In;
    endcase
    case (sel_src2)
      2'b01:   op_rm = MEM_ALU_Res;
      2'b10:   op_rm = WB_Value;
      default: op_rm = Val_Rm_In;
    endcase
  end
`else
  assign op_a  = Val_Rn_In;
  assign op_rm = Val_Rm_In;
`endif

  // Rotated 8-bit immediate; a shift by 32 yields 0, so rotate-by-0 needs no special case.
  logic [31:0] imm8_ext;
  logic [4:0]  imm_rot_amt;
  assign imm8_ext    = {24'b0, Shift_operand_In[7:0]};
  assign imm_rot_amt = {Shift_operand_In[11:8], 1'b0};
  assign imm_rot     = (imm8_ext >> imm_rot_amt) | (imm8_ext << (6'd32 - {1'b0, imm_rot_amt}));

  logic [4:0] sh_amt;
  logic [1:0] sh_type;
  assign sh_amt  = Shift_operand_In[11:7];
  assign sh_type = Shift_operand_In[6:5];

  always_comb begin
    rm_shift = op_rm;
    if (sh_amt != 5'd0) begin
      case (sh_type)
        2'b00: rm_shift = op_rm << sh_amt;
        2'b01: rm_shift = op_rm >> sh_amt;
        2'b10: rm_shift = $unsigned($signed(op_rm) >>> sh_amt);
        default: rm_shift = (op_rm >> sh_amt) | (op_rm << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  always_comb begin
    if (imm_In)                        val2 = imm_rot;
    else if (MEM_R_EN_In | MEM_W_EN_In) val2 = {20'b0, Shift_operand_In};
    else                               val2 = rm_shift;
  end

  // Logical ops keep the architectural C/V; unknown opcodes leave SR untouched.
  always_comb begin
    res      = 32'b0;
    sum      = 33'b0;
    c_new    = SR[1];
    v_new    = SR[0];
    flag_upd = 1'b1;
    case (EXE_CMD_In)
      OP_MOV: res = val2;
      OP_MVN: res = ~val2;
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, op_a} + {1'b0, val2} + {32'b0, (EXE_CMD_In == OP_ADC) & cin};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (op_a[31] == val2[31]) && (res[31] != op_a[31]);
      end
      OP_SUB, OP_SBC: begin
        // A - B - borrow computed as A + ~B + carry_in; carry-out is the no-borrow flag.
        sum   = {1'b0, op_a} + {1'b0, ~val2} + {32'b0, (EXE_CMD_In == OP_SBC) ? cin : 1'b1};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (op_a[31] != val2[31]) && (res[31] != op_a[31]);
      end
      OP_AND: res = op_a & val2;
      OP_ORR: res = op_a | val2;
      OP_EOR: res = op_a ^ val2;
      default: flag_upd = 1'b0;
    endcase
  end

  assign Br_taken = B_In;
  assign Br_addr  = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      WB_EN_Out    <= 1'b0;
      MEM_R_EN_Out <= 1'b0;
      MEM_W_EN_Out <= 1'b0;
      ALU_Res      <= 32'b0;
      Val_Rm_Out   <= 32'b0;
      Dest_Out     <= 4'b0;
    end else if (!freeze) begin
      WB_EN_Out    <= WB_EN_In;
      MEM_R_EN_Out <= MEM_R_EN_In;
      MEM_W_EN_Out <= MEM_W_EN_In;
      ALU_Res      <= res;
      Val_Rm_Out   <= op_rm;
      Dest_Out     <= Dest_In;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      SR <= 4'b0;
    else if (S_In && !freeze && flag_upd)
      SR <= {res[31], (res == 32'b0), c_new, v_new};
  end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes hand-computed expectations, a monitor
// pops one per clock and compares the registered outputs; branch outputs are checked same-cycle.
module tb_exe_stage;
  logic        CLK = 1'b0;
  logic        RST, freeze, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
  logic [3:0]  EXE_CMD_In, Dest_In, SR_In;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic        Br_taken, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
  logic [31:0] Br_addr, ALU_Res, Val_Rm_Out;
  logic [3:0]  SR, Dest_Out;
`ifdef EXE_FORWARDING_EN
  logic [1:0]  sel_src1 = 2'b00, sel_src2 = 2'b00;
  logic [31:0] MEM_ALU_Res = 32'h0, WB_Value = 32'h0;
`endif

  exe_stage dut (
    .CLK(CLK), .RST(RST), .freeze(freeze),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .EXE_CMD_In(EXE_CMD_In), .B_In(B_In), .S_In(S_In), .PC_In(PC_In),
    .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In), .imm_In(imm_In),
    .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
    .Dest_In(Dest_In), .SR_In(SR_In),
`ifdef EXE_FORWARDING_EN
    .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
`endif
    .Br_taken(Br_taken), .Br_addr(Br_addr), .SR(SR),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out),
    .ALU_Res(ALU_Res), .Val_Rm_Out(Val_Rm_Out), .Dest_Out(Dest_Out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wb, mr, mw, dc;
    logic [31:0] alu, rm;
    logic [3:0]  dest, sr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  held, mon_e;
  string mon_nm;
  int    vectors = 0, miscompares = 0;

  task automatic drive(input logic [3:0] cmd, input logic s, input logic im,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sh,
                       input logic [2:0] ctl, input logic [3:0] dst, input logic [3:0] sri);
    @(negedge CLK);
    EXE_CMD_In = cmd; S_In = s; imm_In = im; Val_Rn_In = rn; Val_Rm_In = rm;
    Shift_operand_In = sh; {WB_EN_In, MEM_R_EN_In, MEM_W_EN_In} = ctl;
    Dest_In = dst; SR_In = sri;
  endtask

  // Expected register contents after the coming edge: zeros on reset, previous on freeze.
  task automatic push(input string nm, input logic [31:0] alu, input logic [3:0] sr, input logic dc);
    exp_t e;
    if (RST) begin
      e.wb = 0; e.mr = 0; e.mw = 0; e.dc = 0; e.alu = 0; e.rm = 0; e.dest = 0; e.sr = 0;
    end else if (freeze) begin
      e = held;
    end else begin
      e.wb = WB_EN_In; e.mr = MEM_R_EN_In; e.mw = MEM_W_EN_In; e.dc = dc;
      e.alu = alu; e.rm = Val_Rm_In; e.dest = Dest_In; e.sr = sr;
    end
    held = e;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk_br(input string nm, input logic taken, input logic [31:0] addr, input logic chk_addr);
    vectors++;
    if (Br_taken !== taken || (chk_addr && Br_addr !== addr)) begin
      miscompares++;
      $display("FAIL %s: got taken=%b addr=%h, expected taken=%b addr=%h", nm, Br_taken, Br_addr, taken, addr);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      vectors++;
      if (WB_EN_Out !== mon_e.wb || MEM_R_EN_Out !== mon_e.mr || MEM_W_EN_Out !== mon_e.mw ||
          SR !== mon_e.sr ||
          (!mon_e.dc && (ALU_Res !== mon_e.alu || Val_Rm_Out !== mon_e.rm || Dest_Out !== mon_e.dest))) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b%b%b alu=%h rm=%h dest=%h sr=%b, expected ctl=%b%b%b alu=%h rm=%h dest=%h sr=%b",
                 mon_nm, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, ALU_Res, Val_Rm_Out, Dest_Out, SR,
                 mon_e.wb, mon_e.mr, mon_e.mw, mon_e.alu, mon_e.rm, mon_e.dest, mon_e.sr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with nonzero inputs and freeze asserted: reset must win.
    RST = 1; freeze = 1; B_In = 0; PC_In = 32'h0; Signed_imm_24_In = 24'h0;
    EXE_CMD_In = 4'b0010; S_In = 1; imm_In = 1; Val_Rn_In = 5; Val_Rm_In = 7;
    Shift_operand_In = 12'h203; {WB_EN_In, MEM_R_EN_In, MEM_W_EN_In} = 3'b111;
    Dest_In = 4'hF; SR_In = 4'hF;
    push("reset", 32'h0, 4'b0000, 0);

    drive(4'b0010, 0, 1, 32'd5, 32'h11, 12'h203, 3'b100, 4'd1, 4'h0);
    RST = 0; freeze = 0;
    push("add_imm", 32'h30000005, 4'b0000, 0);
    drive(4'b0100, 1, 0, 32'd3, 32'd5, 12'h000, 3'b100, 4'd2, 4'h0);
    push("sub_neg", 32'hFFFFFFFE, 4'b1000, 0);
    drive(4'b0010, 1, 0, 32'h7FFFFFFF, 32'd1, 12'h000, 3'b100, 4'd3, 4'h0);
    push("add_ovf", 32'h80000000, 4'b1001, 0);
    drive(4'b0111, 1, 0, 32'hF0, 32'h0F, 12'h000, 3'b100, 4'd4, 4'h0);
    push("orr_keep_cv", 32'h000000FF, 4'b0001, 0);

    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 1, 1, i, 32'hA0 + i, 12'h0FF, 3'b011, 4'd9, 4'h0);
      freeze = 1;
      push("freeze_hold", 32'h0, 4'b0, 0);
    end
    drive(4'b0001, 1, 1, 32'd0, 32'd0, 12'h4AB, 3'b100, 4'd5, 4'h0);
    freeze = 0;
    push("release_mov", 32'hAB000000, 4'b1001, 0);

    drive(4'b0001, 0, 0, 32'd0, 32'h80000001, 12'h200, 3'b100, 4'd6, 4'h0);
    push("lsl4", 32'h00000010, 4'b1001, 0);
    drive(4'b0001, 0, 0, 32'd0, 32'h80000001, 12'h220, 3'b100, 4'd6, 4'h0);
    push("lsr4", 32'h08000000, 4'b1001, 0);
    drive(4'b0001, 0, 0, 32'd0, 32'h80000001, 12'h240, 3'b100, 4'd6, 4'h0);
    push("asr4", 32'hF8000000, 4'b1001, 0);
    drive(4'b0001, 0, 0, 32'd0, 32'h80000001, 12'h260, 3'b100, 4'd6, 4'h0);
    push("ror4", 32'h18000000, 4'b1001, 0);
    drive(4'b0001, 0, 0, 32'd0, 32'h80000001, 12'h040, 3'b100, 4'd6, 4'h0);
    push("asr0_passthru", 32'h80000001, 4'b1001, 0);

    drive(4'b0010, 0, 0, 32'h1000, 32'd0, 12'hFFC, 3'b110, 4'd7, 4'h0);
    push("ldr_offset", 32'h00001FFC, 4'b1001, 0);
    drive(4'b0010, 0, 0, 32'h1000, 32'hDEADBEEF, 12'h004, 3'b001, 4'd0, 4'h0);
    push("str_offset", 32'h00001004, 4'b1001, 0);

    drive(4'b0011, 0, 1, 32'd1, 32'd0, 12'h001, 3'b100, 4'd8, 4'b0010);
    push("adc_cin", 32'd3, 4'b1001, 0);
    drive(4'b0101, 1, 1, 32'd5, 32'd0, 12'h002, 3'b100, 4'd8, 4'b0000);
    push("sbc_borrow", 32'd2, 4'b0010, 0);
    drive(4'b0100, 1, 1, 32'd7, 32'd0, 12'h007, 3'b100, 4'd8, 4'b0000);
    push("sub_zero", 32'd0, 4'b0110, 0);
    drive(4'b0011, 1, 1, 32'hFFFFFFFF, 32'd0, 12'h002, 3'b100, 4'd8, 4'b0000);
    push("adc_carry", 32'd1, 4'b0010, 0);
    drive(4'b1001, 1, 1, 32'd0, 32'd0, 12'h000, 3'b100, 4'd10, 4'b0000);
    push("mvn_keep_cv", 32'hFFFFFFFF, 4'b1010, 0);
    drive(4'b0110, 0, 1, 32'hF0F0, 32'd0, 12'h0FF, 3'b100, 4'd11, 4'b0000);
    push("and", 32'h000000F0, 4'b1010, 0);
    drive(4'b1000, 0, 1, 32'hFF, 32'd0, 12'h00F, 3'b100, 4'd12, 4'b0000);
    push("eor", 32'h000000F0, 4'b1010, 0);
    drive(4'b0000, 1, 1, 32'd5, 32'd0, 12'h001, 3'b100, 4'd13, 4'b0000);
    push("undef_op", 32'd0, 4'b1010, 0);
    drive(4'b0010, 0, 0, 32'd1, 32'd2, 12'h000, 3'b000, 4'd0, 4'b0000);
    push("bubble", 32'd0, 4'b1010, 1);

    drive(4'b0100, 1, 1, 32'd1, 32'd0, 12'h001, 3'b000, 4'd0, 4'b0000);
    B_In = 1; PC_In = 32'h100; Signed_imm_24_In = 24'hFFFFFE;
    #1 chk_br("br_back", 1'b1, 32'h000000F8, 1'b1);
    push("br_with_s", 32'd0, 4'b0110, 0);
    drive(4'b0000, 0, 0, 32'd0, 32'd0, 12'h000, 3'b000, 4'd0, 4'b0000);
    PC_In = 32'h200; Signed_imm_24_In = 24'h000010;
    #1 chk_br("br_fwd", 1'b1, 32'h00000240, 1'b1);
    push("br_no_s", 32'd0, 4'b0110, 0);

    drive(4'b0010, 1, 1, 32'd5, 32'd7, 12'h203, 3'b111, 4'hF, 4'hF);
    B_In = 0; RST = 1; freeze = 1;
    #1 chk_br("no_branch", 1'b0, 32'h0, 1'b0);
    push("reset_again", 32'd0, 4'b0000, 0);

    @(negedge CLK);
    RST = 0; freeze = 1;
    repeat (2) @(posedge CLK);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
